hangman_draw_ctrl: RTL and testbench

// Draw scheduler between the game FSM and vga_adapter/letter_ram. Sequences full-screen clears on

---
 rtl/hangman_pkg.sv | 39 +++
 rtl/draw_raster_counter.sv | 36 +++
 rtl/hangman_draw_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hangman_draw_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared encodings, screen geometry and colour table for the hangman draw path.
package hangman_pkg;

  localparam int unsigned SLOTS      = 6;
  localparam int unsigned CODE_W     = 5;
  localparam int unsigned WORD_W     = SLOTS * CODE_W;
  localparam int unsigned LETTERS    = 26;
  localparam int unsigned GLYPH_W    = 64;
  localparam int unsigned X_W        = 9;
  localparam int unsigned Y_W        = 8;
  localparam int unsigned COLOUR_W   = 3;

  localparam int unsigned SLOT_X0    = 16;
  localparam int unsigned SLOT_PITCH = 48;
  localparam int unsigned SLOT_Y     = 112;
  localparam int unsigned SCREEN_W   = 320;
  localparam int unsigned SCREEN_H   = 240;

  localparam logic [CODE_W-1:0]   DASH_CODE   = 5'd26;
  localparam logic [CODE_W-1:0]   CODE_UNUSED = 5'd27;
  localparam logic [COLOUR_W-1:0] FG_COLOUR   = 3'b000;

  typedef enum logic [1:0] {
    GS_START    = 2'd0,
    GS_INGAME   = 2'd1,
    GS_WINGAME  = 2'd2,
    GS_LOSTGAME = 2'd3
  } game_state_e;

  function automatic logic [COLOUR_W-1:0] bg_colour(input game_state_e gs);
    case (gs)
      GS_START:   return 3'b000;
      GS_INGAME:  return 3'b111;
      GS_WINGAME: return 3'b010;
      default:    return 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/draw_raster_counter.sv
// Full-screen x/y raster counter: x inner, y outer, wraps to (0,0) after the last pixel.
module draw_raster_counter
  import hangman_pkg::*;
#(
  parameter int unsigned WIDTH  = SCREEN_W,
  parameter int unsigned HEIGHT = SCREEN_H
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           restart,
  input  logic           en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last_c
);

  localparam logic [X_W-1:0] X_MAX = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(HEIGHT - 1);

  assign last_c = (x == X_MAX) && (y == Y_MAX);

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hangman_draw_ctrl.sv
// Draw scheduler: clears the screen on game_state changes and redraws the six word-slot
// glyphs on mask changes, one pixel write per cycle through a single plot port.
module hangman_draw_ctrl
  import hangman_pkg::*;
#(
  parameter int unsigned DISP_W      = SCREEN_W,
  parameter int unsigned DISP_H      = SCREEN_H,
  parameter int unsigned SLOT_X_ORG  = SLOT_X0,
  parameter int unsigned SLOT_X_STEP = SLOT_PITCH,
  parameter int unsigned SLOT_Y_ORG  = SLOT_Y
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          game_state,
  input  logic [WORD_W-1:0]   word,
  input  logic [LETTERS-1:0]  mask,
  output logic [CODE_W-1:0]   rom_addr,
  input  logic [GLYPH_W-1:0]  rom_q,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SCAN, S_FETCH, S_WAIT, S_DRAW
  } state_e;

  state_e               state;
  game_state_e          cur_gs;
  logic [LETTERS-1:0]   prev_mask;
  logic                 redraw_pending;
  logic [2:0]           slot;
  logic [5:0]           pix;
  logic [GLYPH_W-1:0]   glyph;

  logic                 state_chg_c;
  logic                 mask_chg_c;
  logic [4:0]           code_lsb_c;
  logic [CODE_W-1:0]    code_c;
  logic [31:0]          mask_ext_c;
  logic                 reveal_c;
  logic [COLOUR_W-1:0]  bg_c;
  logic [X_W-1:0]       slot_x_c;
  logic                 slot_done_c;
  logic [X_W-1:0]       rx;
  logic [Y_W-1:0]       ry;
  logic                 raster_last_c;

  assign state_chg_c = (game_state_e'(game_state) != cur_gs);
  assign mask_chg_c  = (mask != prev_mask);
  assign code_lsb_c  = 5'(CODE_W * 32'(slot));
  assign code_c      = word[code_lsb_c +: CODE_W];
  assign mask_ext_c  = 32'(prev_mask);
  assign reveal_c    = mask_ext_c[code_c] || (cur_gs == GS_WINGAME) || (cur_gs == GS_LOSTGAME);
  assign bg_c        = bg_colour(cur_gs);
  assign slot_x_c    = X_W'(SLOT_X_ORG + SLOT_X_STEP * 32'(slot));
  assign slot_done_c = ((state == S_SCAN) && (code_c >= CODE_UNUSED)) ||
                       ((state == S_DRAW) && (pix == 6'd63));

  draw_raster_counter #(
    .WIDTH  (DISP_W),
    .HEIGHT (DISP_H)
  ) u_raster (
    .clk     (clk),
    .reset   (reset),
    .restart (state_chg_c),
    .en      ((state == S_CLEAR) && !state_chg_c),
    .x       (rx),
    .y       (ry),
    .last_c  (raster_last_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_CLEAR;
      cur_gs         <= game_state_e'(game_state);
      prev_mask      <= mask;
      redraw_pending <= 1'b0;
      slot           <= '0;
      pix            <= '0;
      glyph          <= '0;
      rom_addr       <= '0;
      vga_x          <= '0;
      vga_y          <= '0;
      vga_colour     <= '0;
      vga_plot       <= 1'b0;
      busy           <= 1'b1;
    end else begin
      vga_plot  <= 1'b0;
      busy      <= 1'b1;
      prev_mask <= mask;
      if (state_chg_c) begin
        // A game_state change aborts whatever is in flight and restarts the clear.
        state          <= S_CLEAR;
        cur_gs         <= game_state_e'(game_state);
        redraw_pending <= 1'b0;
      end else begin
        if (mask_chg_c && (state inside {S_SCAN, S_FETCH, S_WAIT, S_DRAW}))
          redraw_pending <= 1'b1;
        case (state)
          S_IDLE: begin
            busy <= 1'b0;
            if (mask_chg_c && (cur_gs == GS_INGAME)) begin
              state <= S_SCAN;
              slot  <= '0;
              busy  <= 1'b1;
            end
          end
          S_CLEAR: begin
            vga_x      <= rx;
            vga_y      <= ry;
            vga_colour <= bg_c;
            vga_plot   <= 1'b1;
            if (raster_last_c) begin
              slot <= '0;
              if (cur_gs == GS_START) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= S_SCAN;
              end
            end
          end
          S_SCAN: begin
            if (code_c < CODE_UNUSED) begin
              rom_addr <= reveal_c ? code_c : DASH_CODE;
              state    <= S_FETCH;
            end
          end
          S_FETCH: state <= S_WAIT;
          S_WAIT: begin
            glyph <= rom_q;
            pix   <= '0;
            state <= S_DRAW;
          end
          S_DRAW: begin
            vga_x      <= slot_x_c + X_W'(pix[2:0]);
            vga_y      <= Y_W'(SLOT_Y_ORG) + Y_W'(pix[5:3]);
            vga_colour <= glyph[pix] ? FG_COLOUR : bg_c;
            vga_plot   <= 1'b1;
            pix        <= pix + 1'b1;
          end
          default: state <= S_IDLE;
        endcase

        // Slot finished (skipped or drawn): advance, or close the pass.
        if (slot_done_c) begin
          if (slot == 3'(SLOTS - 1)) begin
            slot           <= '0;
            redraw_pending <= 1'b0;
            if (redraw_pending || mask_chg_c) begin
              state <= S_SCAN;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            slot  <= slot + 1'b1;
            state <= S_SCAN;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hangman_draw_ctrl.sv
// Directed bench for hangman_draw_ctrl: plot-stream scoreboard plus shadow framebuffer vs golden image.
module tb_hangman_draw_ctrl;

  localparam int W     = 128;
  localparam int H     = 48;
  localparam int X0    = 16;
  localparam int PITCH = 20;
  localparam int Y0    = 24;
  localparam int PASS_MAX = 6 * 67 + 6;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  game_state;
  logic [29:0] word;
  logic [25:0] mask;
  logic [4:0]  rom_addr;
  logic [63:0] rom_q;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;

  hangman_draw_ctrl #(
    .DISP_W      (W),
    .DISP_H      (H),
    .SLOT_X_ORG  (X0),
    .SLOT_X_STEP (PITCH),
    .SLOT_Y_ORG  (Y0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .game_state (game_state),
    .word       (word),
    .mask       (mask),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Letter RAM model: arbitrary distinct glyph per code, one-cycle read latency.
  function automatic logic [63:0] glyph_of(input logic [4:0] code);
    return (64'(code) + 64'd1) * 64'h9E37_79B9_7F4A_7C15;
  endfunction

  always @(posedge clk) rom_q <= glyph_of(rom_addr);

  function automatic logic [2:0] bg_of(input logic [1:0] gs);
    case (gs)
      2'd0:    return 3'b000;
      2'd1:    return 3'b111;
      2'd2:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Displayed code for slot s, or -1 when the slot is unused.
  function automatic int slot_code(input int s);
    logic [4:0]  c;
    logic [31:0] m;
    c = 5'(word >> (5 * s));
    m = 32'(mask);
    if (c >= 5'd27) return -1;
    if (m[c] || game_state >= 2'd2) return int'(c);
    return 26;
  endfunction

  function automatic logic [2:0] golden(input int x, input int y);
    logic [2:0]  bg;
    logic [63:0] g;
    int          code;
    int          dx;
    bg = bg_of(game_state);
    if (game_state == 2'd0) return bg;
    if (y < Y0 || y >= Y0 + 8) return bg;
    for (int s = 0; s < 6; s++) begin
      dx = x - (X0 + PITCH * s);
      if (dx >= 0 && dx < 8) begin
        code = slot_code(s);
        if (code < 0) return bg;
        g = glyph_of(5'(code));
        return g[(y - Y0) * 8 + dx] ? 3'b000 : bg;
      end
    end
    return bg;
  endfunction

  pix_t       exp_q[$];
  int         mism = 0;
  int         extra = 0;
  int         oob = 0;
  pix_t       first_obs;
  pix_t       first_exp;
  logic [2:0] fb [H][W];

  always @(negedge clk) begin
    pix_t o;
    pix_t e;
    if (!reset && vga_plot) begin
      o = {vga_x, vga_y, vga_colour};
      if (int'(vga_x) >= W || int'(vga_y) >= H) oob++;
      else fb[int'(vga_y)][int'(vga_x)] = vga_colour;
      if (exp_q.size() == 0) begin
        extra++;
      end else begin
        e = exp_q.pop_front();
        if (e !== o) begin
          if (mism == 0) begin
            first_obs = o;
            first_exp = e;
          end
          mism++;
        end
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_clear(input logic [1:0] gs);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({9'(x), 8'(y), bg_of(gs)});
  endtask

  task automatic push_pass();
    logic [63:0] g;
    logic [2:0]  bg;
    int          code;
    if (game_state == 2'd0) return;
    bg = bg_of(game_state);
    for (int s = 0; s < 6; s++) begin
      code = slot_code(s);
      if (code >= 0) begin
        g = glyph_of(5'(code));
        for (int p = 0; p < 64; p++)
          exp_q.push_back({9'(X0 + PITCH * s + p % 8), 8'(Y0 + p / 8), g[p] ? 3'b000 : bg});
      end
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    repeat (3) step();
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, " idle timeout"}, longint'(busy !== 1'b0), 0);
  endtask

  task automatic wait_drawn(input string tag, input int left);
    int n;
    n = 0;
    while (exp_q.size() > left && n < 20000) begin
      step();
      n++;
    end
    chk({tag, " reach draw"}, longint'(exp_q.size() > left), 0);
  endtask

  task automatic check_scoreboard(input string tag);
    int bad;
    bad = 0;
    if (mism != 0)
      $display("  %s first stream diff: observed x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
               tag, first_obs.x, first_obs.y, first_obs.c, first_exp.x, first_exp.y, first_exp.c);
    chk({tag, " stream"}, mism, 0);
    chk({tag, " leftover"}, exp_q.size(), 0);
    chk({tag, " extra plots"}, extra, 0);
    chk({tag, " bounds"}, oob, 0);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (fb[y][x] !== golden(x, y)) bad++;
    chk({tag, " image"}, bad, 0);
    mism  = 0;
    extra = 0;
    exp_q.delete();
  endtask

  initial begin
    reset      = 1'b1;
    game_state = 2'd0;
    word       = {5'd27, 5'd27, 5'd27, 5'd27, 5'd27, 5'd7};
    mask       = '0;
    repeat (3) step();
    chk("reset plot", vga_plot, 0);
    chk("reset x", vga_x, 0);
    chk("reset y", vga_y, 0);
    chk("reset colour", vga_colour, 0);
    chk("reset rom_addr", rom_addr, 0);
    chk("reset busy", busy, 1);

    // START: clear only, no slot drawing
    push_clear(2'd0);
    reset = 1'b0;
    wait_idle("start", W * H + 100);
    check_scoreboard("start");
    chk("start rom_addr", rom_addr, 0);

    // INGAME: clear white, slot 0 shows dash
    game_state = 2'd1;
    push_clear(2'd1);
    push_pass();
    wait_idle("ingame", W * H + PASS_MAX + 20);
    check_scoreboard("ingame");
    chk("ingame rom_addr", rom_addr, 26);

    // Guess letter 7 while idle: single redraw pass
    mask[7] = 1'b1;
    push_pass();
    wait_idle("guess7", PASS_MAX);
    check_scoreboard("guess7");
    chk("guess7 rom_addr", rom_addr, 7);

    // Full word, then a mask change mid-DRAW of slot 2 -> exactly one extra pass
    word    = {5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
    mask[1] = 1'b1;
    push_pass();
    wait_drawn("pending", 6 * 64 - (2 * 64 + 20));
    mask[0] = 1'b1;
    push_pass();
    wait_idle("pending", 2 * PASS_MAX + 20);
    check_scoreboard("pending");
    chk("pending rom_addr", rom_addr, 26);

    // Lose mid-DRAW with a simultaneous mask change: restart clear, then one pass of real letters
    mask[2] = 1'b1;
    push_pass();
    wait_drawn("lost", 6 * 64 - 10);
    game_state = 2'd3;
    mask[4]    = 1'b1;
    exp_q.delete();
    push_clear(2'd3);
    push_pass();
    step();
    chk("lost gap plot", vga_plot, 0);
    step();
    chk("lost restart plot", vga_plot, 1);
    chk("lost restart x", vga_x, 0);
    chk("lost restart y", vga_y, 0);
    chk("lost restart colour", vga_colour, 3'b100);
    wait_idle("lost", W * H + PASS_MAX + 20);
    check_scoreboard("lost");
    chk("lost rom_addr", rom_addr, 5);

    // Win, then back to INGAME in the middle of the clear: clear restarts at (0,0)
    game_state = 2'd2;
    push_clear(2'd2);
    push_pass();
    repeat (100) step();
    game_state = 2'd1;
    exp_q.delete();
    push_clear(2'd1);
    push_pass();
    step();
    chk("midclear gap plot", vga_plot, 0);
    step();
    chk("midclear restart x", vga_x, 0);
    chk("midclear restart y", vga_y, 0);
    chk("midclear restart colour", vga_colour, 3'b111);
    wait_idle("midclear", W * H + PASS_MAX + 20);
    check_scoreboard("midclear");

    // Back to START: black screen, no slots
    game_state = 2'd0;
    push_clear(2'd0);
    wait_idle("restart", W * H + 100);
    check_scoreboard("restart");
    chk("restart busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
